// File: rtl/banner_scroller.sv
// banner_scroller: message buffer and 4-digit glyph scroller
// feeding the seven-segment display-mux/decoder stage.
module banner_scroller #(
  parameter int         MAX_LEN    = 32,
  parameter int         TICK_DIV   = 25000000,
  parameter logic [3:0] BLANK_CODE = 4'h6,
  parameter int         LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_valid,
  input  logic [3:0]       wr_code,
  input  logic             wr_last,
  output logic             wr_ready,
  input  logic             scroll_en,
  output logic [3:0]       digit0,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic [LEN_W-1:0] msg_len,
  output logic             scrolling,
  output logic             wrap_pulse
);

  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    SCROLL
  } state_t;

  state_t           state;
  logic [3:0]       mem [MAX_LEN];
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] tick;
  logic [LEN_W-1:0] len_inc;
  logic             accept;
  logic             tick_end;
  logic             rd_last;

  assign wr_ready = (state != SCROLL) && !clear;
  assign accept   = wr_valid && wr_ready;
  assign len_inc  = msg_len + LEN_W'(1);
  assign tick_end = (tick == CNT_W'(TICK_DIV - 1));
  assign rd_last  = (LEN_W'(rd_ptr) == msg_len - LEN_W'(1));

  // Glyph storage; appends at the current length, never reset.
  always_ff @(posedge clock) begin
    if (!reset && accept) begin
      mem[msg_len[PTR_W-1:0]] <= wr_code;
    end
  end

  // Load/scroll state machine with registered display outputs.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state      <= EMPTY;
      msg_len    <= '0;
      tick       <= '0;
      rd_ptr     <= '0;
      wrap_pulse <= 1'b0;
      scrolling  <= 1'b0;
      digit0     <= BLANK_CODE;
      digit1     <= BLANK_CODE;
      digit2     <= BLANK_CODE;
      digit3     <= BLANK_CODE;
    end else begin
      wrap_pulse <= 1'b0;
      unique case (state)
        EMPTY, LOAD: begin
          if (accept) begin
            msg_len <= len_inc;
            if (wr_last || len_inc == LEN_W'(MAX_LEN)) begin
              state     <= SCROLL;
              scrolling <= 1'b1;
              tick      <= '0;
              rd_ptr    <= '0;
            end else begin
              state <= LOAD;
            end
          end
        end
        SCROLL: begin
          if (scroll_en) begin
            if (tick_end) begin
              tick       <= '0;
              digit0     <= digit1;
              digit1     <= digit2;
              digit2     <= digit3;
              digit3     <= mem[rd_ptr];
              rd_ptr     <= rd_last ? '0 : rd_ptr + PTR_W'(1);
              wrap_pulse <= rd_last;
            end else begin
              tick <= tick + CNT_W'(1);
            end
          end
        end
        default: begin
          state     <= EMPTY;
          scrolling <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_banner_scroller.sv
// tb_banner_scroller: table vectors, hand sequences and random
// stimulus checked against a step-count reference model.
module tb_banner_scroller;

  localparam int         MAX_LEN = 8;
  localparam int         TICK    = 4;
  localparam logic [3:0] BLANK   = 4'h6;
  localparam int         LEN_W   = $clog2(MAX_LEN + 1);

  logic             clock = 1'b0;
  logic             reset, clear, wr_valid, wr_last, scroll_en;
  logic [3:0]       wr_code;
  logic             wr_ready;
  logic [3:0]       digit0, digit1, digit2, digit3;
  logic [LEN_W-1:0] msg_len;
  logic             scrolling, wrap_pulse;
  logic [21:0]      outs;

  int total = 0;
  int bad   = 0;

  // reference model: message queue, mode, enabled cycles in scroll
  logic [3:0] mq[$];
  int         m_mode;
  int         m_e;
  logic       m_wrap;

  banner_scroller #(
    .MAX_LEN   (MAX_LEN),
    .TICK_DIV  (TICK),
    .BLANK_CODE(BLANK)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .wr_valid  (wr_valid),
    .wr_code   (wr_code),
    .wr_last   (wr_last),
    .wr_ready  (wr_ready),
    .scroll_en (scroll_en),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .msg_len   (msg_len),
    .scrolling (scrolling),
    .wrap_pulse(wrap_pulse)
  );

  assign outs = {digit0, digit1, digit2, digit3,
                 msg_len, scrolling, wrap_pulse};

  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // digit i shows the glyph of step k-3+i (BLANK before step 1)
  function automatic logic [3:0] mdig(input int i);
    int k;
    int s;
    k = m_e / TICK;
    s = k - 3 + i;
    if (m_mode != 2 || s < 1) return BLANK;
    return mq[(s - 1) % mq.size()];
  endfunction

  function automatic logic [21:0] mexp();
    logic [LEN_W-1:0] l;
    l = LEN_W'(mq.size());
    return {mdig(0), mdig(1), mdig(2), mdig(3),
            l, (m_mode == 2), m_wrap};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_mode = 0;
    m_e    = 0;
    m_wrap = 1'b0;
  endtask

  task automatic model_step();
    if (reset || clear) begin
      model_reset();
    end else begin
      m_wrap = 1'b0;
      if (m_mode != 2) begin
        if (wr_valid) begin
          mq.push_back(wr_code);
          if (wr_last || mq.size() == MAX_LEN) begin
            m_mode = 2;
            m_e    = 0;
          end else begin
            m_mode = 1;
          end
        end
      end else if (scroll_en) begin
        m_e++;
        if (m_e % TICK == 0 && (m_e / TICK) % mq.size() == 0)
          m_wrap = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    #1;
    chk("ready", 32'(wr_ready), 32'((m_mode != 2) && !clear));
    model_step();
    @(posedge clock);
    #1;
    chk("outs", 32'(outs), 32'(mexp()));
  endtask

  typedef struct {
    logic        rst, clr, vld;
    logic [3:0]  code;
    logic        last, en;
    int          n;
    logic [15:0] dig;
    int          len;
    logic        scr, wrap;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(input logic r, c, vl,
                             input logic [3:0] cd,
                             input logic l, en,
                             input int n,
                             input logic [15:0] d,
                             input int len,
                             input logic s, w);
    vec_t x;
    x.rst = r;  x.clr = c;  x.vld = vl; x.code = cd;
    x.last = l; x.en = en;  x.n = n;    x.dig = d;
    x.len = len; x.scr = s; x.wrap = w;
    return x;
  endfunction

  initial begin
    reset = 1'b1; clear = 1'b0; wr_valid = 1'b0;
    wr_code = '0; wr_last = 1'b0; scroll_en = 1'b0;
    @(posedge clock);
    #1;
    model_reset();

    // reset state and "HELLO " load/scroll
    tv.push_back(v(1,0,0,4'h0,0,0, 1,16'h6666,0,0,0));
    tv.push_back(v(0,0,1,4'h2,0,0, 1,16'h6666,1,0,0));
    tv.push_back(v(0,0,1,4'hE,0,0, 1,16'h6666,2,0,0));
    tv.push_back(v(0,0,1,4'h3,0,0, 1,16'h6666,3,0,0));
    tv.push_back(v(0,0,1,4'h3,0,0, 1,16'h6666,4,0,0));
    tv.push_back(v(0,0,1,4'h0,0,0, 1,16'h6666,5,0,0));
    tv.push_back(v(0,0,1,4'h6,1,0, 1,16'h6666,6,1,0));
    tv.push_back(v(0,0,0,4'h0,0,1,16,16'h2E33,6,1,0));
    tv.push_back(v(0,0,0,4'h0,0,1, 8,16'h3306,6,1,1));
    tv.push_back(v(0,0,0,4'h0,0,1, 1,16'h3306,6,1,0));
    tv.push_back(v(0,0,0,4'h0,0,1, 3,16'h3062,6,1,0));
    // freeze keeps the partial count
    tv.push_back(v(0,0,0,4'h0,0,1, 2,16'h3062,6,1,0));
    tv.push_back(v(0,0,0,4'h0,0,0,20,16'h3062,6,1,0));
    tv.push_back(v(0,0,0,4'h0,0,1, 1,16'h3062,6,1,0));
    tv.push_back(v(0,0,0,4'h0,0,1, 1,16'h062E,6,1,0));
    // clear with a write mid-scroll, then a single glyph
    tv.push_back(v(0,1,1,4'h5,0,1, 1,16'h6666,0,0,0));
    tv.push_back(v(0,0,1,4'hB,1,0, 1,16'h6666,1,1,0));
    tv.push_back(v(0,0,0,4'h0,0,1, 4,16'h666B,1,1,1));
    tv.push_back(v(0,0,0,4'h0,0,1, 4,16'h66BB,1,1,1));
    tv.push_back(v(0,0,0,4'h0,0,1, 8,16'hBBBB,1,1,1));
    // fill to MAX_LEN without wr_last; extra write dropped
    tv.push_back(v(0,1,0,4'h0,0,0, 1,16'h6666,0,0,0));
    tv.push_back(v(0,0,1,4'hA,0,0, 7,16'h6666,7,0,0));
    tv.push_back(v(0,0,1,4'hC,0,0, 1,16'h6666,8,1,0));
    tv.push_back(v(0,0,1,4'hD,0,0, 1,16'h6666,8,1,0));
    tv.push_back(v(0,0,0,4'h0,0,1,32,16'hAAAC,8,1,1));
    tv.push_back(v(0,0,0,4'h0,0,1, 4,16'hAACA,8,1,0));
    // reset mid-load, then a 2-glyph message
    tv.push_back(v(1,0,0,4'h0,0,0, 1,16'h6666,0,0,0));
    tv.push_back(v(0,0,1,4'h1,0,0, 3,16'h6666,3,0,0));
    tv.push_back(v(1,0,1,4'h1,0,0, 1,16'h6666,0,0,0));
    tv.push_back(v(0,0,1,4'h7,0,0, 1,16'h6666,1,0,0));
    tv.push_back(v(0,0,1,4'h8,1,0, 1,16'h6666,2,1,0));
    tv.push_back(v(0,0,0,4'h0,0,1, 4,16'h6667,2,1,0));
    tv.push_back(v(0,0,0,4'h0,0,1, 4,16'h6678,2,1,1));
    tv.push_back(v(0,0,0,4'h0,0,1, 4,16'h6787,2,1,0));

    foreach (tv[i]) begin
      reset     = tv[i].rst;
      clear     = tv[i].clr;
      wr_valid  = tv[i].vld;
      wr_code   = tv[i].code;
      wr_last   = tv[i].last;
      scroll_en = tv[i].en;
      for (int c = 0; c < tv[i].n; c++) cycle();
      chk($sformatf("vec%0d", i), 32'(outs),
          32'({tv[i].dig, LEN_W'(tv[i].len), tv[i].scr, tv[i].wrap}));
    end

    // hand sequence: clear blocks wr_ready in the same cycle
    reset = 1'b0; clear = 1'b0; wr_valid = 1'b1;
    wr_code = 4'h9; wr_last = 1'b1; scroll_en = 1'b1;
    #1;
    chk("scroll_ready", 32'(wr_ready), 32'(0));
    clear = 1'b1;
    #1;
    chk("clear_ready", 32'(wr_ready), 32'(0));
    cycle();
    clear = 1'b0;
    #1;
    chk("empty_ready", 32'(wr_ready), 32'(1));
    cycle();
    wr_valid = 1'b0;
    for (int c = 0; c < TICK; c++) cycle();
    chk("first_glyph", 32'(digit3), 32'(4'h9));
    chk("first_wrap", 32'(wrap_pulse), 32'(1));

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      clear     = ($urandom_range(0, 59) == 0);
      wr_valid  = ($urandom_range(0, 1) == 1);
      wr_code   = 4'($urandom_range(0, 15));
      wr_last   = ($urandom_range(0, 5) == 0);
      scroll_en = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/banner_scroller.md
Name: banner_scroller

Overview:
Upstream message stage for the 4-digit seven-segment rotating banner. Accepts a message of 4-bit glyph codes over a valid/ready write port and stores it in an internal buffer. Produces the four per-digit glyph codes (digit0..digit3), shifting one new glyph in at each scroll step and wrapping through the message indefinitely. The downstream display-mux/decoder stage consumes digit0..digit3, with digit3 driving the rightmost digit and digit0 the leftmost.

Parameters:
MAX_LEN, 32, message buffer depth in glyphs (≥1).
TICK_DIV, 25000000, clock cycles of scroll_en-high per scroll step (0.25 s at 100 MHz).
BLANK_CODE, 4'h6, glyph code shown on all digits after reset or clear (decodes to space downstream).
LEN_W, $clog2(MAX_LEN+1), width of msg_len (derived).

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
clear  in  1  synchronous, 1-cycle pulse; discards the message and returns to EMPTY
wr_valid  in  1  write request
wr_code  in  4  glyph code to append; stored unmodified
wr_last  in  1  qualifies wr_valid; marks the final glyph of the message
wr_ready  out  1  buffer accepts a write this cycle
scroll_en  in  1  scroll timing enable; low freezes the banner
digit0  out  4  leftmost glyph (oldest)
digit1  out  4  glyph
digit2  out  4  glyph
digit3  out  4  rightmost glyph (newest)
msg_len  out  LEN_W  number of glyphs stored
scrolling  out  1  high in SCROLL state
wrap_pulse  out  1  1-cycle pulse when the read pointer wraps to 0

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: digit0..3 = BLANK_CODE; msg_len = 0; state EMPTY; tick counter = 0; rd_ptr = 0; wrap_pulse = 0; scrolling = 0. Buffer contents are not reset.
- Priority order: reset > clear > write/step.
- wr_ready = (state is EMPTY or LOAD) && !clear. This is combinational; clear blocks acceptance in the same cycle.
- A write is accepted when wr_valid && wr_ready.
- EMPTY: an accepted write stores to mem[0] and sets msg_len = 1. Next state is SCROLL if wr_last, else LOAD.
- LOAD: an accepted write stores to mem[msg_len] and increments msg_len. Next state is SCROLL if wr_last or the new msg_len == MAX_LEN; otherwise remain in LOAD. LOAD is never occupied with msg_len == MAX_LEN, so there is no overflow path.
- Entry to SCROLL: tick counter = 0, rd_ptr = 0. Digits keep their current values (BLANK_CODE after reset/clear).
- SCROLL: wr_ready = 0. When scroll_en = 1 the counter increments. When the counter reaches TICK_DIV-1 and scroll_en = 1, a step occurs and the counter returns to 0. When scroll_en = 0, the counter and digits hold.
- Step, all updates in the same edge:
  - digit0 <= digit1, digit1 <= digit2, digit2 <= digit3, digit3 <= mem[rd_ptr].
  - rd_ptr <= (rd_ptr == msg_len-1) ? 0 : rd_ptr+1.
  - wrap_pulse = 1 in the cycle after the step whose rd_ptr was msg_len-1.
- First step lands TICK_DIV enabled cycles after entering SCROLL. A glyph is visible on digit3 for exactly TICK_DIV enabled cycles.
- msg_len = 1: every step loads mem[0] and every step pulses wrap_pulse.
- clear (any state): next cycle state EMPTY, msg_len = 0, digits = BLANK_CODE, counter = 0, rd_ptr = 0, wrap_pulse = 0. A write presented in the same cycle is dropped.
- Reset mid-LOAD or mid-SCROLL: identical to the reset values above; any partial message is discarded.
- scrolling = (state == SCROLL), registered.

Test Plan:
- Load "HELLO " (2,E,3,3,0,6; wr_last on the 6th), TICK_DIV=4, scroll_en=1 -> msg_len=6, scrolling=1. After 4 steps digit0..3 = 2,E,3,3. After step 6, wrap_pulse=1 for 1 cycle. Step 7 puts digit3 = 2.
- MAX_LEN=4, write 5 glyphs with no wr_last -> 4 accepted; wr_ready=0 after the 4th edge; scrolling=1; 5th glyph never stored; msg_len=4.
- During SCROLL, hold scroll_en=0 for 20 cycles -> digits and counter unchanged. Re-assert -> the next step arrives after the remaining count only (no reset of the counter).
- Single glyph 4'hB with wr_last -> steps fill digits B,B,B,B in 4 steps; wrap_pulse on every step.
- clear asserted with wr_valid=1 mid-SCROLL -> wr_ready=0 that cycle; next cycle digits = 6,6,6,6, msg_len=0, scrolling=0. The following write lands at mem[0].
- reset mid-LOAD after 3 writes -> msg_len=0, digits=BLANK_CODE, wr_ready=1; a new 2-glyph message loads and scrolls correctly.
